// File: rtl/uart_rx_monitor_pkg.sv
// Shared FSM encoding, constants and sizing helper for the UART receive monitor.
package uart_rx_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [7:0] LF = 8'h0A;

    // Bit timer counts 0..clks_per_bit-1.
    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_monitor_fifo.sv
// Generic show-ahead byte FIFO with push/pop, full/empty and fill count.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module uart_rx_monitor_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_vld,
    input  logic [DW-1:0]          push_dat,
    input  logic                   pop,
    output logic [DW-1:0]          head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push_vld && (!full || do_pop);

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver with byte buffer and line-end marking; UART_RX_MONITOR_FIFO_EN selects FIFO vs holding register.
// Latency: byte pushed the cycle after the stop sample; rx_valid/rx_count/line_end update one cycle later.
// Backpressure: valid/ready drain; a byte arriving with the buffer full and no pop is dropped and sets overrun.
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2956,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        rxd,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        overrun_clr,
    output logic                        line_end
);

    localparam int TW = timer_width(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rxd_meta;
    logic          rxs;
    logic          rxs_d;
    rx_state_t     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          push_vld;
    logic [7:0]    push_dat;
    logic          push_ok;
    logic          pop;
    logic          full;

    // Synchronizer and edge history reset to the idle line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
            rxs_d    <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            push_vld  <= 1'b0;
            push_dat  <= '0;
            frame_err <= 1'b0;
        end else begin
            push_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    if (rxs_d && !rxs) state <= START;
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rxs) begin
                            push_vld <= 1'b1;
                            push_dat <= shreg;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                BREAK: begin
                    // Line held low past the stop bit: wait for idle before hunting again.
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_vld && (!full || pop);

`ifdef UART_RX_MONITOR_FIFO_EN
    logic empty;

    uart_rx_monitor_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (push_ok),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (rx_data),
        .full     (full),
        .empty    (empty),
        .count    (rx_count)
    );

    assign rx_valid = !empty;
`else
    logic       hold_vld;
    logic [7:0] hold_dat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (push_ok) begin
            hold_vld <= 1'b1;
            hold_dat <= push_dat;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign full     = hold_vld;
    assign rx_valid = hold_vld;
    assign rx_data  = hold_dat;
    assign rx_count = {{(CW-1){1'b0}}, hold_vld};
`endif

    // A fresh overrun in the same cycle as the clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun  <= 1'b0;
            line_end <= 1'b0;
        end else begin
            line_end <= push_ok && (push_dat == LF);
            overrun  <= (overrun && !overrun_clr) || (push_vld && !push_ok);
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: directed vector table, hand-written corner sequences and random frames vs a queue model.
module tb_uart_rx_monitor;

    localparam int C = 16;
    localparam int D = 4;
`ifdef UART_RX_MONITOR_FIFO_EN
    localparam int CAP = D;
`else
    localparam int CAP = 1;
`endif

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                rxd = 1'b1;
    logic                rx_ready = 1'b0;
    logic                overrun_clr = 1'b0;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [$clog2(D):0]  rx_count;
    logic                frame_err;
    logic                overrun;
    logic                line_end;

    int         tests = 0;
    int         failed = 0;
    int         fe_seen = 0;
    int         le_seen = 0;
    int         pops = 0;
    int         exp_fe = 0;
    int         exp_le = 0;
    logic       exp_ovr = 1'b0;
    logic [7:0] exp_q[$];
    int         rdy_mode = 0;

    typedef struct {
        bit         is_glitch;
        logic [7:0] dat;
        logic       stop_bit;
        int         gap;
        int         exp_pops;
        int         exp_fe;
        int         exp_le;
    } vec_t;

    always #5 clk = ~clk;

    uart_rx_monitor #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_count    (rx_count),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .line_end    (line_end)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Mid-cycle observer: a pop happens at the next edge when valid and ready are both high now.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (frame_err) fe_seen++;
            if (line_end) le_seen++;
            if (rx_valid && rx_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL pop_unexpected: popped 0x%0h with no byte expected", rx_data);
                end else begin
                    chk("pop_data", rx_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode == 2) rx_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 1) rx_ready = 1'b1;
    endtask

    // Transaction-level model: decides the fate of a frame from buffer occupancy.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input bit pop_with_push);
        if (!stop_bit) begin
            exp_fe++;
        end else if (exp_q.size() < CAP || pop_with_push || rdy_mode != 0) begin
            exp_q.push_back(b);
            if (b == 8'h0A) exp_le++;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    // pop_tick/clr_tick: tick index within the frame at which rx_ready/overrun_clr pulse for one cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_tick, input int clr_tick);
        logic [9:0] bits;
        int n;
        bits = {stop_bit, b, 1'b0};
        model_frame(b, stop_bit, pop_tick >= 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            for (int j = 0; j < C; j++) begin
                if (pop_tick >= 0) rx_ready = (n == pop_tick);
                if (clr_tick >= 0) overrun_clr = (n == clr_tick);
                tick();
                n++;
            end
        end
        rxd = 1'b1;
    endtask

    task automatic glitch(input int len);
        rxd = 1'b0;
        repeat (len) tick();
        rxd = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_rx_count"}, rx_count, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_line_end"}, line_end, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        int         p0, f0, l0;
        logic [7:0] pb;
        int         r;
        logic [7:0] b;

        vecs[0] = '{1'b0, 8'h55, 1'b1, 0,  1, 0, 0};
        vecs[1] = '{1'b0, 8'h0A, 1'b1, 4,  1, 0, 1};
        vecs[2] = '{1'b1, 8'd5,  1'b1, 12, 0, 0, 0};
        vecs[3] = '{1'b0, 8'hA3, 1'b0, 20, 0, 1, 0};
        vecs[4] = '{1'b0, 8'h31, 1'b1, 4,  1, 0, 0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0,  1, 0, 0};
        vecs[6] = '{1'b0, 8'hFF, 1'b1, 4,  1, 0, 0};
        vecs[7] = '{1'b0, 8'h0A, 1'b0, 20, 0, 1, 0};

        fork
            monitor_loop();
        join_none

        repeat (5) tick();
        chk_reset_outputs("por");
        rstn = 1'b1;
        repeat (5) tick();

        // Directed vectors with the consumer always ready.
        rdy_mode = 1;
        for (int v = 0; v < 8; v++) begin
            p0 = pops;
            f0 = fe_seen;
            l0 = le_seen;
            if (vecs[v].is_glitch) glitch(int'(vecs[v].dat));
            else send_frame(vecs[v].dat, vecs[v].stop_bit, -1, -1);
            repeat (vecs[v].gap) tick();
            chk($sformatf("vec%0d_pops", v), pops - p0, vecs[v].exp_pops);
            chk($sformatf("vec%0d_frame_err", v), fe_seen - f0, vecs[v].exp_fe);
            chk($sformatf("vec%0d_line_end", v), le_seen - l0, vecs[v].exp_le);
        end
        chk("vec_rx_count", rx_count, 0);

        // Overflow with the consumer stalled.
        rdy_mode = 0;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
        repeat (4) tick();
        chk("ovf_rx_count", rx_count, exp_q.size());
        chk("ovf_overrun", overrun, exp_ovr);
        chk("ovf_rx_valid", rx_valid, 1);
        chk("ovf_head", rx_data, 8'h01);
        rdy_mode = 1;
        repeat (3 * D + 4) tick();
        chk("drain_rx_count", rx_count, 0);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_overrun_sticky", overrun, 1);
        rdy_mode = 0;
        rx_ready = 1'b0;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        tick();
        chk("clr_overrun", overrun, 0);

        // Full buffer: pop coinciding with push keeps the byte.
        for (int i = 0; i < CAP; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1);
        repeat (4) tick();
        chk("fill_rx_count", rx_count, CAP);
        send_frame(8'h20, 1'b1, 155, -1);
        repeat (4) tick();
        chk("pp_rx_count", rx_count, CAP);
        chk("pp_overrun", overrun, exp_ovr);
        chk("pp_head", rx_data, exp_q[0]);

        // Clear and new overrun in the same cycle: overrun must stay set.
        send_frame(8'h30, 1'b1, -1, 155);
        repeat (4) tick();
        chk("clr_vs_ovf_overrun", overrun, exp_ovr);
        chk("clr_vs_ovf_rx_count", rx_count, CAP);

        // Reset mid-way through the data bits of 0x7E.
        pb = 8'h7E;
        rxd = 1'b0;
        repeat (C) tick();
        for (int k = 0; k < 4; k++) begin
            rxd = pb[k];
            repeat (C) tick();
        end
        rstn = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("midrst");
        rstn = 1'b1;
        repeat (8) tick();
        chk("post_rst_rx_count", rx_count, 0);
        rdy_mode = 1;
        p0 = pops;
        send_frame(8'h42, 1'b1, -1, -1);
        repeat (6) tick();
        chk("post_rst_pops", pops - p0, 1);
        chk("post_rst_left", exp_q.size(), 0);

        // Random frames, errors and glitches with a randomly stalling consumer.
        rdy_mode = 2;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 19);
            if (r < 3) begin
                glitch($urandom_range(1, 6));
                repeat (12 + $urandom_range(0, 8)) tick();
            end else if (r < 6) begin
                send_frame(8'($urandom), 1'b0, -1, -1);
                repeat (C + $urandom_range(0, 10)) tick();
            end else begin
                b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                send_frame(b, 1'b1, -1, -1);
                repeat ($urandom_range(0, 20)) tick();
            end
        end
        rdy_mode = 1;
        repeat (20) tick();
        chk("final_frame_err_count", fe_seen, exp_fe);
        chk("final_line_end_count", le_seen, exp_le);
        chk("final_left", exp_q.size(), 0);
        chk("final_overrun", overrun, exp_ovr);
        chk("final_rx_count", rx_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
